// File: rtl/spike_window_classifier_pkg.sv
// snn_classifier_pkg: shared FSM states and sizing helpers for spike_window_classifier
package snn_classifier_pkg;
  typedef enum logic [1:0] {IDLE, COUNT, RESOLVE, DONE} state_t;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic logic [31:0] sat_max(input int w);
    return (32'd1 << w) - 32'd1;
  endfunction
endpackage

// File: rtl/spike_window_classifier_if.sv
// spike_window_classifier_if: result valid/ready handshake with the registered class outputs
interface spike_window_classifier_if
  import snn_classifier_pkg::*;
#(
  parameter int N = 2,
  parameter int CW = 8,
  parameter int IW = idx_w(N)
);
  logic result_valid;
  logic result_ready;
  logic [IW-1:0] winner;
  logic tie;
  logic [N*CW-1:0] spike_counts;
  modport master(output result_valid, winner, tie, spike_counts, input result_ready);
  modport slave(input result_valid, winner, tie, spike_counts, output result_ready);
endinterface

// File: rtl/spike_sat_counter.sv
// spike_sat_counter: per-neuron spike counter that clears on request and saturates at all-ones
module spike_sat_counter
  import snn_classifier_pkg::*;
#(
  parameter int CW = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic [CW-1:0] count
);
  localparam logic [CW-1:0] MAX = CW'(sat_max(CW));
  always_ff @(posedge clk)
    if (reset || clear) count <= '0;
    else if (inc && count != MAX) count <= count + 1'b1;
endmodule

// File: rtl/spike_window_classifier.sv
// spike_window_classifier: counts output spikes over a window of enabled steps, then argmax-scans one neuron per cycle.
// Define SPIKE_CLASSIFIER_ABORT_EN to add an abort input that cancels COUNT/RESOLVE.
module spike_window_classifier
  import snn_classifier_pkg::*;
#(
  parameter int N = 2,
  parameter int CW = 8,
  parameter int WW = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic start,
  input  logic [WW-1:0] window_len,
  input  logic [N-1:0] spikes_in,
`ifdef SPIKE_CLASSIFIER_ABORT_EN
  input  logic abort,
`endif
  output logic busy,
  spike_window_classifier_if.master res
);
  localparam int IW = idx_w(N);
  localparam logic [IW-1:0] LAST = IW'(N - 1);
  state_t state, nxt;
  logic [WW-1:0] remaining;
  logic [IW-1:0] k, best_idx;
  logic [CW-1:0] best_cnt, cur;
  logic tie_r, go, quit;
  logic [CW-1:0] cnt [N];
  assign go = state == IDLE && start;
`ifdef SPIKE_CLASSIFIER_ABORT_EN
  assign quit = abort && (state == COUNT || state == RESOLVE);
`else
  assign quit = 1'b0;
`endif
  assign cur = cnt[k];
  for (genvar i = 0; i < N; i++) begin : g_cnt
    spike_sat_counter #(.CW(CW)) u_cnt (
      .clk(clk),
      .reset(reset),
      .clear(go),
      .inc(state == COUNT && enable && spikes_in[i]),
      .count(cnt[i])
    );
  end
  always_comb begin
    res.spike_counts = '0;
    for (int i = 0; i < N; i++) res.spike_counts[i*CW +: CW] = cnt[i];
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start ? (window_len == '0 ? RESOLVE : COUNT) : IDLE;
      COUNT:   nxt = enable && remaining == WW'(1) ? RESOLVE : COUNT;
      RESOLVE: nxt = k == LAST ? DONE : RESOLVE;
      DONE:    nxt = res.result_ready ? IDLE : DONE;
      default: nxt = IDLE;
    endcase
    if (quit) nxt = IDLE;
  end
  // First scanned neuron seeds the best unconditionally; later ones replace only when strictly greater
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      remaining <= '0;
      k <= '0;
      best_idx <= '0;
      best_cnt <= '0;
      tie_r <= 1'b0;
    end else begin
      state <= nxt;
      if (go) begin
        remaining <= window_len;
        k <= '0;
        best_idx <= '0;
        best_cnt <= '0;
        tie_r <= 1'b0;
      end
      if (state == COUNT && enable) remaining <= remaining - 1'b1;
      if (state == RESOLVE) begin
        k <= k + 1'b1;
        if (k == '0 || cur > best_cnt) begin
          best_idx <= k;
          best_cnt <= cur;
          tie_r <= 1'b0;
        end else if (cur == best_cnt) tie_r <= 1'b1;
      end
    end
  assign busy = state != IDLE;
  assign res.result_valid = state == DONE;
  assign res.winner = best_idx;
  assign res.tie = tie_r;
endmodule
